mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, `clock`; `reset` SHALL be synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- DATA_WIDTH, default 32, data bus width.
- ADDR_WIDTH, default 32, address bus width.
- TIMEOUT, default 15, maximum wait cycles for mem_ready (range 1..255).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- im_req  in  1  instruction-fetch read request
- im_addr  in  ADDR_WIDTH  fetch address
- im_rdata  out  DATA_WIDTH  fetch read data, registered
- im_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data access request
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_rdata  out  DATA_WIDTH  data read data, registered
- dm_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  shared memory access strobe
- mem_we  out  1  shared memory write enable
- mem_addr  out  ADDR_WIDTH  shared memory address
- mem_wdata  out  DATA_WIDTH  shared memory write data
- mem_rdata  in  DATA_WIDTH  shared memory read data
- mem_ready  in  1  memory completion, valid while mem_en=1
- bus_err  out  1  one-cycle timeout pulse, coincident with ack
- grant_dm  out  1  current/last owner: 0=IM, 1=DM

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY_IM and BUSY_DM.
REQ-005 In IDLE, a request SHALL be eligible only if its req=1 and its own ack=0 in that cycle; a req coinciding with its own ack SHALL be ignored.
REQ-006 In IDLE, with exactly one eligible request, the FSM SHALL move to that requester's BUSY state at the next edge.
REQ-007 In IDLE, with both requests eligible, the FSM SHALL grant the requester opposite to grant_dm (round-robin).
REQ-008 On grant, grant_dm SHALL update to the granted requester.
REQ-009 On grant, mem_addr, mem_we and mem_wdata SHALL be registered from the granted requester and held constant until the state leaves BUSY.
- IM grant: mem_we=0, mem_wdata=0.
REQ-010 mem_en SHALL be 1 exactly while the state is BUSY_IM or BUSY_DM.
REQ-011 Requester inputs SHALL be ignored after grant; a req dropping mid-transaction SHALL NOT abort the transaction.
REQ-012 In a BUSY state with mem_ready=1, the block SHALL, at the next edge:
- return to IDLE;
- pulse the owner's ack for exactly one cycle;
- for a read, load mem_rdata into the owner's rdata register.
REQ-013 On a write, the owner's rdata register SHALL be left unchanged.
REQ-014 The non-owner's ack and rdata SHALL be left unchanged by any transaction.
REQ-015 A wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready=0.
REQ-016 If the wait counter equals TIMEOUT while mem_ready=0, the block SHALL, at the next edge:
- return to IDLE;
- pulse the owner's ack and bus_err together;
- load 0 into the owner's rdata on a read.
REQ-017 Minimum latency SHALL be 2 cycles from req sampled to ack, when mem_ready=1 in the first BUSY cycle.
REQ-018 Back-to-back transactions SHALL have at least one IDLE cycle between them.
REQ-019 im_rdata and dm_rdata SHALL hold their value until overwritten per REQ-012, REQ-013 or REQ-016.

Reset
REQ-020 Synchronous reset SHALL force the following at the next edge:
- state=IDLE;
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
- im_ack=0, dm_ack=0, bus_err=0;
- im_rdata=0, dm_rdata=0;
- wait counter=0;
- grant_dm=1, so IM wins the first contention.
REQ-021 Reset asserted during BUSY SHALL abandon the transaction with no ack and no bus_err, and mem_en SHALL be 0 from the next edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single IM read: im_req=1, im_addr=0x100, mem_ready=1 on first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_en high 1 cycle with mem_addr=0x100, mem_we=0; im_ack pulse 2 cycles after req; im_rdata=0xDEADBEEF.
- Contention after reset: im_req=dm_req=1 held continuously -> grants alternate IM, DM, IM, with an IDLE cycle between each.
- DM write with 3 wait cycles: dm_we=1, dm_addr=0x40, dm_wdata=0x12345678 -> mem_we=1, address and data stable 4 cycles; dm_ack once; dm_rdata unchanged.
- Timeout, TIMEOUT=15, mem_ready stuck 0 on a DM read -> mem_en high 16 cycles; dm_ack and bus_err pulse together; dm_rdata=0.
- Reset mid-transaction: reset on second BUSY cycle -> mem_en=0 next edge; no ack; grant_dm=1; all outputs at reset values.
- Req drop and hold: im_req dropped during BUSY -> im_ack still pulses; im_req held through ack -> no regrant in the ack cycle, regrant the cycle after.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one shared memory port.
// Round-robin on contention, one transaction at a time, wait-state timeout
// reported as bus_err together with the owner's ack.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  im_req,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_rdata,
  output logic                  im_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  bus_err,
  output logic                  grant_dm
);

  // Wait counter is sized for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IM = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  im_elig;
  logic                  dm_elig;
  logic                  pick_dm;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] rd_load;

  // A requester whose ack is high this cycle is not eligible, which forces
  // an IDLE gap before the same master can be served again.
  assign im_elig = im_req & ~im_ack;
  assign dm_elig = dm_req & ~dm_ack;

  // DM wins if it is the only one asking, or on contention when IM was last.
  assign pick_dm = dm_elig & (~im_elig | ~grant_dm);

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));

  // Timed-out reads return zero instead of whatever is on mem_rdata.
  assign rd_load = mem_ready ? mem_rdata : '0;

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      im_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      bus_err   <= 1'b0;
      im_rdata  <= '0;
      dm_rdata  <= '0;
      grant_dm  <= 1'b1;
    end else begin
      im_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (im_elig || dm_elig) begin
            grant_dm <= pick_dm;
            mem_en   <= 1'b1;
            wait_cnt <= '0;
            if (pick_dm) begin
              state     <= BUSY_DM;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              state     <= BUSY_IM;
              mem_we    <= 1'b0;
              mem_addr  <= im_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_IM, BUSY_DM: begin
          if (mem_ready || timeout_hit) begin
            state   <= IDLE;
            mem_en  <= 1'b0;
            bus_err <= ~mem_ready;
            if (state == BUSY_DM) begin
              dm_ack <= 1'b1;
              if (!mem_we) dm_rdata <= rd_load;
            end else begin
              im_ack <= 1'b1;
              if (!mem_we) im_rdata <= rd_load;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and acks,
// independent monitors pop and compare when the DUT shows them.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;
  logic        grant_dm;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .grant_dm(grant_dm)
  );

  typedef struct {
    logic        dm;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
    int          cyc;
  } grant_t;

  typedef struct {
    logic        dm;
    logic        err;
    logic [31:0] im_rd;
    logic [31:0] dm_rd;
    int          cyc;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     ready_delay = 0;
  int     c0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory contents seen by the arbiter.
  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic dm, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input int len, input int gcyc);
    grant_t g;
    g.dm = dm; g.addr = addr; g.we = we; g.wdata = wdata; g.len = len; g.cyc = gcyc;
    gq.push_back(g);
  endtask

  task automatic push_ack(input logic dm, input logic err, input logic [31:0] im_rd,
                          input logic [31:0] dm_rd, input int acyc);
    ack_t a;
    a.dm = dm; a.err = err; a.im_rd = im_rd; a.dm_rd = dm_rd; a.cyc = acyc;
    aq.push_back(a);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_en",    64'(mem_en),    64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_im_ack",    64'(im_ack),    64'(0));
    chk("rst_dm_ack",    64'(dm_ack),    64'(0));
    chk("rst_bus_err",   64'(bus_err),   64'(0));
    chk("rst_im_rdata",  64'(im_rdata),  64'(0));
    chk("rst_dm_rdata",  64'(dm_rdata),  64'(0));
    chk("rst_grant_dm",  64'(grant_dm),  64'(1));
  endtask

  // Memory responder: raises mem_ready on BUSY cycle number ready_delay.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_en) begin
        mem_ready = (busy_cnt == ready_delay);
        busy_cnt++;
      end else begin
        mem_ready = 1'b0;
        busy_cnt = 0;
      end
      mem_rdata = model(mem_addr);
    end
  end

  // Grant monitor: owner, address, control at grant; stability and length of BUSY.
  initial begin
    grant_t cur;
    logic   en_q;
    logic   have_cur;
    int     len_cnt;
    en_q = 1'b0;
    have_cur = 1'b0;
    len_cnt = 0;
    forever begin
      @(negedge clock);
      if (mem_en && !en_q) begin
        len_cnt = 1;
        if (gq.size() == 0) begin
          total++;
          bad++;
          have_cur = 1'b0;
          $display("FAIL unexpected_grant cyc=%0d addr=0x%0h required=none", cyc, mem_addr);
        end else begin
          cur = gq.pop_front();
          have_cur = 1'b1;
          chk("grant_owner", 64'(grant_dm),  64'(cur.dm));
          chk("grant_addr",  64'(mem_addr),  64'(cur.addr));
          chk("grant_we",    64'(mem_we),    64'(cur.we));
          chk("grant_wdata", 64'(mem_wdata), 64'(cur.wdata));
          if (cur.cyc != 0) chk("grant_cycle", 64'(cyc), 64'(cur.cyc));
        end
      end else if (mem_en && en_q) begin
        len_cnt++;
        if (have_cur) begin
          chk("hold_addr",  64'(mem_addr),  64'(cur.addr));
          chk("hold_we",    64'(mem_we),    64'(cur.we));
          chk("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
      end else if (!mem_en && en_q) begin
        if (have_cur) chk("busy_len", 64'(len_cnt), 64'(cur.len));
        have_cur = 1'b0;
      end
      en_q = mem_en;
    end
  end

  // Ack monitor: which ack, bus_err, both rdata registers, and timing.
  initial begin
    ack_t e;
    forever begin
      @(negedge clock);
      if (im_ack || dm_ack) begin
        if (aq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack cyc=%0d im_ack=%0b dm_ack=%0b required=none",
                   cyc, im_ack, dm_ack);
        end else begin
          e = aq.pop_front();
          chk("ack_im",    64'(im_ack),   64'(!e.dm));
          chk("ack_dm",    64'(dm_ack),   64'(e.dm));
          chk("ack_err",   64'(bus_err),  64'(e.err));
          chk("im_rdata",  64'(im_rdata), 64'(e.im_rd));
          chk("dm_rdata",  64'(dm_rdata), 64'(e.dm_rd));
          if (e.cyc != 0) chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (bus_err) begin
        total++;
        bad++;
        $display("FAIL bus_err_without_ack cyc=%0d actual=1 required=0", cyc);
      end
    end
  end

  // Directed scenarios.
  initial begin
    reset = 1'b1; im_req = 1'b0; im_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    ticks(3);
    reset = 1'b0;
    check_reset_vals();
    tick();

    // Single IM read, zero wait states.
    ready_delay = 0;
    c0 = cyc;
    push_grant(1'b0, 32'h100, 1'b0, 32'h0, 1, c0 + 1);
    push_ack(1'b0, 1'b0, 32'hDEADBEEF, 32'h0, c0 + 2);
    im_addr = 32'h100; im_req = 1'b1;
    tick();
    im_req = 1'b0;
    ticks(4);

    // Contention right after reset: IM, DM, IM.
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ready_delay = 0;
    im_addr = 32'h200; dm_addr = 32'h300; dm_we = 1'b0; dm_wdata = 32'h0;
    c0 = cyc;
    push_grant(1'b0, 32'h200, 1'b0, 32'h0, 1, c0 + 1);
    push_grant(1'b1, 32'h300, 1'b0, 32'h0, 1, c0 + 3);
    push_grant(1'b0, 32'h200, 1'b0, 32'h0, 1, c0 + 5);
    push_ack(1'b0, 1'b0, 32'hA5A50200, 32'h0,        c0 + 2);
    push_ack(1'b1, 1'b0, 32'hA5A50200, 32'hA5A50300, c0 + 4);
    push_ack(1'b0, 1'b0, 32'hA5A50200, 32'hA5A50300, c0 + 6);
    im_req = 1'b1; dm_req = 1'b1;
    ticks(5);
    im_req = 1'b0; dm_req = 1'b0;
    ticks(4);

    // DM write with three wait states; dm_rdata must not change.
    ready_delay = 3;
    c0 = cyc;
    push_grant(1'b1, 32'h40, 1'b1, 32'h12345678, 4, c0 + 1);
    push_ack(1'b1, 1'b0, 32'hA5A50200, 32'hA5A50300, c0 + 5);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    tick();
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
    ticks(7);

    // DM read with mem_ready stuck low: timeout after 16 BUSY cycles.
    ready_delay = 1000;
    c0 = cyc;
    push_grant(1'b1, 32'h80, 1'b0, 32'h0, 16, c0 + 1);
    push_ack(1'b1, 1'b1, 32'hA5A50200, 32'h0, c0 + 17);
    dm_req = 1'b1; dm_addr = 32'h80;
    tick();
    dm_req = 1'b0;
    ticks(20);

    // Reset on the second BUSY cycle abandons the transaction silently.
    ready_delay = 1000;
    c0 = cyc;
    push_grant(1'b0, 32'h180, 1'b0, 32'h0, 2, c0 + 1);
    im_addr = 32'h180; im_req = 1'b1;
    tick();
    im_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals();
    ticks(3);

    // Request dropped while BUSY still completes.
    ready_delay = 2;
    c0 = cyc;
    push_grant(1'b0, 32'h140, 1'b0, 32'h0, 3, c0 + 1);
    push_ack(1'b0, 1'b0, 32'hA5A50140, 32'h0, c0 + 4);
    im_addr = 32'h140; im_req = 1'b1;
    tick();
    im_req = 1'b0;
    ticks(6);

    // Request held through ack: no regrant in the ack cycle, regrant after it.
    ready_delay = 0;
    c0 = cyc;
    push_grant(1'b0, 32'h1C0, 1'b0, 32'h0, 1, c0 + 1);
    push_grant(1'b0, 32'h1C0, 1'b0, 32'h0, 1, c0 + 4);
    push_ack(1'b0, 1'b0, 32'hA5A501C0, 32'h0, c0 + 2);
    push_ack(1'b0, 1'b0, 32'hA5A501C0, 32'h0, c0 + 5);
    im_addr = 32'h1C0; im_req = 1'b1;
    ticks(4);
    im_req = 1'b0;
    ticks(5);

    chk("grant_queue_empty", 64'(gq.size()), 64'(0));
    chk("ack_queue_empty",   64'(aq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
